mem_wb_stage: RTL

Parametrised MEM→WB pipeline stage register with valid/ready handshake, flush, and write-back forwarding lookup. Sits between the memory-access stage and the register-file write port. It replaces the fixed 16-bit, always-advancing MEM/WB latch. It adds back-pressure, bubble tracking, an optional two-entry skid buffer and a same-cycle forwarding probe for the decode/execute hazard logic.

---
 rtl/mem_wb_stage_if.sv | 47 ++++
 rtl/mem_wb_stage.sv | 114 +++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_if
// Description : MEM->WB handshake, data and forwarding-probe bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CTRL_W = 3
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [REG_AW-1:0] in_rs;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_alu_data;
    logic [DATA_W-1:0] in_mem_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rd;
    logic [DATA_W-1:0] out_alu_data;
    logic [DATA_W-1:0] out_mem_data;
    logic [DATA_W-1:0] out_wdata;
    logic [REG_AW-1:0] out_waddr;
    logic [REG_AW-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output flush, in_valid, in_ctrl, in_rs, in_rd, in_alu_data, in_mem_data,
               out_ready, fwd_addr,
        input  in_ready, out_valid, out_ctrl, out_rs, out_rd, out_alu_data,
               out_mem_data, out_wdata, out_waddr, fwd_hit, fwd_data
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_rs, in_rd, in_alu_data, in_mem_data,
               out_ready, fwd_addr,
        output in_ready, out_valid, out_ctrl, out_rs, out_rd, out_alu_data,
               out_mem_data, out_wdata, out_waddr, fwd_hit, fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM->WB pipeline register with valid/ready, flush and a
//               write-back forwarding probe. Define MEM_WB_SKID_EN for a
//               two-entry (head + skid) build with a registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CTRL_W = 3
) (
    input  wire logic     clock,
    input  wire logic     reset,
    mem_wb_stage_if.slave bus
);
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
    } entry_t;

    entry_t r_h;
    logic   r_h_valid;
    entry_t w_in_entry;
    logic   w_in_ready;
    logic   w_accept;
    logic   w_consume;

    assign w_in_entry = '{ctrl: bus.in_ctrl, rs: bus.in_rs, rd: bus.in_rd,
                          alu: bus.in_alu_data, mem: bus.in_mem_data};
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_consume  = r_h_valid & bus.out_ready;

`ifdef MEM_WB_SKID_EN
    entry_t r_s;
    logic   r_s_valid;

    // in_ready comes straight from a flop, so out_ready never reaches it
    assign w_in_ready = ~r_s_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_h       <= '0;
            r_h_valid <= 1'b0;
            r_s       <= '0;
            r_s_valid <= 1'b0;
        end else if (bus.flush) begin
            r_h_valid <= 1'b0;
            r_h.ctrl  <= '0;
            r_s_valid <= 1'b0;
            r_s.ctrl  <= '0;
        end else if (w_consume && r_s_valid) begin
            r_h       <= r_s;
            r_h_valid <= 1'b1;
            r_s_valid <= 1'b0;
        end else if (w_consume) begin
            if (w_accept) begin
                r_h <= w_in_entry;
            end else begin
                r_h_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Head still waiting on WB: park the newcomer behind it
            if (r_h_valid) begin
                r_s       <= w_in_entry;
                r_s_valid <= 1'b1;
            end else begin
                r_h       <= w_in_entry;
                r_h_valid <= 1'b1;
            end
        end
    end
`else
    assign w_in_ready = ~r_h_valid | bus.out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_h       <= '0;
            r_h_valid <= 1'b0;
        end else if (bus.flush) begin
            r_h_valid <= 1'b0;
            r_h.ctrl  <= '0;
        end else if (w_accept) begin
            r_h       <= w_in_entry;
            r_h_valid <= 1'b1;
        end else if (w_consume) begin
            r_h_valid <= 1'b0;
        end
    end
`endif

    logic [DATA_W-1:0] w_wdata;
    logic [REG_AW-1:0] w_waddr;

    assign w_wdata = r_h.ctrl[2] ? r_h.mem : r_h.alu;
    assign w_waddr = r_h.ctrl[1] ? r_h.rs  : r_h.rd;

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_h_valid;
    assign bus.out_ctrl     = r_h.ctrl;
    assign bus.out_rs       = r_h.rs;
    assign bus.out_rd       = r_h.rd;
    assign bus.out_alu_data = r_h.alu;
    assign bus.out_mem_data = r_h.mem;
    assign bus.out_wdata    = w_wdata;
    assign bus.out_waddr    = w_waddr;
    assign bus.fwd_hit      = r_h_valid & r_h.ctrl[0] & (w_waddr == bus.fwd_addr);
    assign bus.fwd_data     = w_wdata;
endmodule
`default_nettype wire
